// File: rtl/nand_cpu_sequencer.sv
// nand_cpu_sequencer: multi-cycle control FSM for the NAND CPU.
// Walks each instruction through FETCH, DECODE, EXEC, optional MEM, then WB.
// It owns the PC, EPC, the imem/dmem handshakes, the register write strobes and HALT.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   imem_req/imem_ack, ir_load        instruction fetch handshake; ir_load marks the IR capture
//   d_*                               decoder control fields; held stable from DECODE through WB
//   cond_flag, r_value                branch condition and register-r target
//   dmem_req/dmem_we/dmem_ack         data memory handshake
//   a_we, r_we, link_value            register-file write strobes and the JRL link value
//   pc, epc, halted, resume, state    architectural state and status
module nand_cpu_sequencer #(
  parameter int                    PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0]   INT_BASE = 'h10
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                ir_load,
  input  logic                d_write_a,
  input  logic                d_write_r,
  input  logic                d_ld,
  input  logic                d_st,
  input  logic                d_br,
  input  logic                d_jrl,
  input  logic                d_interrupt,
  input  logic                d_halt,
  input  logic [3:0]          d_immdt,
  input  logic                cond_flag,
  input  logic [PC_WIDTH-1:0] r_value,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                a_we,
  output logic                r_we,
  output logic [PC_WIDTH-1:0] link_value,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] epc,
  output logic                halted,
  input  logic                resume,
  output logic [2:0]          state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  logic                st_q, st_d;     // current MEM access is a store
  logic                rst_q;          // reset was sampled on the last edge
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] int_vec;

  // Both adds wrap naturally at PC_WIDTH bits.
  assign pc_inc  = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign int_vec = INT_BASE + {{(PC_WIDTH-6){1'b0}}, d_immdt, 2'b00};

  // The fetch request is held off for the cycle that follows a sampled reset,
  // so an aborted fetch is seen to drop before the fresh one starts.
  assign imem_req   = (state_q == S_FETCH) && !rst_q;
  assign ir_load    = imem_req && imem_ack;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req && st_q;
  assign a_we       = (state_q == S_WB) && d_write_a;
  assign r_we       = (state_q == S_WB) && (d_write_r || d_jrl);
  assign link_value = pc_inc;
  assign pc         = pc_q;
  assign epc        = epc_q;
  assign halted     = (state_q == S_HALT);
  assign state      = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    st_d    = st_q;
    case (state_q)
      S_FETCH: begin
        if (ir_load) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (d_halt) begin
          pc_d    = pc_inc;
          state_d = S_HALT;
        end else if (d_ld || d_st) begin
          st_d    = d_st;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) state_d = S_WB;
      end
      S_WB: begin
        if (d_interrupt) begin
          epc_d = pc_inc;
          pc_d  = int_vec;
        end else if (d_br) begin
          pc_d  = cond_flag ? r_value : pc_inc;
        end else if (d_jrl) begin
          pc_d  = r_value;
        end else begin
          pc_d  = pc_inc;
        end
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (resume) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      st_q    <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      st_q    <= st_d;
      rst_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nand_cpu_sequencer.sv
// Testbench for nand_cpu_sequencer: a table of instructions is driven through
// the handshakes; a negedge monitor scores each completed instruction against
// the expectation queued when it was issued. HALT and reset-abort are hand sequences.
module tb_nand_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, ir_load;
  logic        d_write_a, d_write_r, d_ld, d_st, d_br, d_jrl, d_interrupt, d_halt;
  logic [3:0]  d_immdt;
  logic        cond_flag;
  logic [15:0] r_value;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        a_we, r_we;
  logic [15:0] link_value, pc, epc;
  logic        halted, resume;
  logic [2:0]  state;

  nand_cpu_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000), .INT_BASE(16'h0010)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .d_write_a(d_write_a), .d_write_r(d_write_r), .d_ld(d_ld), .d_st(d_st),
    .d_br(d_br), .d_jrl(d_jrl), .d_interrupt(d_interrupt), .d_halt(d_halt),
    .d_immdt(d_immdt), .cond_flag(cond_flag), .r_value(r_value),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .a_we(a_we), .r_we(r_we), .link_value(link_value),
    .pc(pc), .epc(epc), .halted(halted), .resume(resume), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ld, st, br, jrl, intr, wa, wr, imm, cond, rval, iw, dw;
    int e_pc, e_epc, e_link, e_cyc, e_a, e_r, e_dreq, e_dwe;
  } vec_t;

  vec_t tbl[13];
  vec_t exp_q[$];
  vec_t e_cur;

  int n_tests = 0;
  int n_fail  = 0;

  bit mon_en = 1'b0;
  bit pend   = 1'b0;
  int cyc = 0, na = 0, nr = 0, ndreq = 0, ndwe = 0, nir = 0, nbad = 0, nboth = 0;
  logic [15:0] wb_link;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, required 'h%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: accumulates per-instruction activity, compares one
  // negedge after WB when the PC update has landed.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend) begin
          pend = 1'b0;
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e_cur = exp_q.pop_front();
            chk("pc",        int'(pc),      e_cur.e_pc);
            chk("epc",       int'(epc),     e_cur.e_epc);
            chk("link",      int'(wb_link), e_cur.e_link);
            chk("cycles",    cyc,           e_cur.e_cyc);
            chk("a_we_cnt",  na,            e_cur.e_a);
            chk("r_we_cnt",  nr,            e_cur.e_r);
            chk("dreq_cnt",  ndreq,         e_cur.e_dreq);
            chk("dwe_cnt",   ndwe,          e_cur.e_dwe);
            chk("ir_load",   nir,           1);
            chk("strobe_out_of_wb", nbad,   0);
            chk("req_overlap",      nboth,  0);
          end
          cyc = 0; na = 0; nr = 0; ndreq = 0; ndwe = 0; nir = 0; nbad = 0; nboth = 0;
        end
        cyc++;
        if (a_we) na++;
        if (r_we) nr++;
        if (dmem_req) ndreq++;
        if (dmem_req && dmem_we) ndwe++;
        if (ir_load) nir++;
        if ((a_we || r_we) && state != 3'd4) nbad++;
        if (imem_req && dmem_req) nboth++;
        if (state == 3'd4) begin
          wb_link = link_value;
          pend    = 1'b1;
        end
      end
    end
  end

  // Drives one instruction with fixed ack delays; called at posedge+1 in FETCH.
  task automatic run_instr(input vec_t v);
    exp_q.push_back(v);
    d_ld = (v.ld != 0); d_st = (v.st != 0); d_br = (v.br != 0); d_jrl = (v.jrl != 0);
    d_interrupt = (v.intr != 0); d_write_a = (v.wa != 0); d_write_r = (v.wr != 0);
    d_halt = 1'b0; d_immdt = 4'(v.imm); cond_flag = (v.cond != 0); r_value = 16'(v.rval);
    for (int i = 0; i <= v.iw; i++) begin
      imem_ack = (i == v.iw);
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    chk("state_decode", int'(state), 1);
    @(posedge clk); #1;
    chk("state_exec", int'(state), 2);
    @(posedge clk); #1;
    if (v.ld != 0 || v.st != 0) begin
      chk("state_mem", int'(state), 3);
      for (int i = 0; i <= v.dw; i++) begin
        dmem_ack = (i == v.dw);
        @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
    end
    chk("state_wb", int'(state), 4);
    @(posedge clk); #1;
    chk("state_fetch", int'(state), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    //          ld st br jrl int wa wr imm cond rval     iw dw  e_pc     e_epc   e_link   cyc a  r  dreq dwe
    tbl[0]  = '{0, 0, 0, 0,  0,  1, 0, 0,  0,   0,       0, 0,  'h0001,  'h0000, 'h0001,  4,  1, 0, 0,   0};
    tbl[1]  = '{0, 1, 0, 0,  0,  0, 0, 0,  0,   0,       0, 3,  'h0002,  'h0000, 'h0002,  8,  0, 0, 4,   4};
    tbl[2]  = '{1, 0, 0, 0,  0,  0, 1, 0,  0,   0,       2, 0,  'h0003,  'h0000, 'h0003,  7,  0, 1, 1,   0};
    tbl[3]  = '{0, 0, 1, 0,  0,  0, 0, 0,  1,   'h0040,  0, 0,  'h0040,  'h0000, 'h0004,  4,  0, 0, 0,   0};
    tbl[4]  = '{0, 0, 1, 0,  0,  0, 0, 0,  0,   'h0080,  0, 0,  'h0041,  'h0000, 'h0041,  4,  0, 0, 0,   0};
    tbl[5]  = '{0, 0, 1, 0,  0,  0, 0, 0,  1,   'h0005,  0, 0,  'h0005,  'h0000, 'h0042,  4,  0, 0, 0,   0};
    tbl[6]  = '{0, 0, 0, 1,  0,  0, 1, 0,  0,   'h0100,  0, 0,  'h0100,  'h0000, 'h0006,  4,  0, 1, 0,   0};
    tbl[7]  = '{0, 0, 1, 0,  0,  0, 0, 0,  1,   'h0020,  0, 0,  'h0020,  'h0000, 'h0101,  4,  0, 0, 0,   0};
    tbl[8]  = '{0, 0, 0, 0,  1,  0, 0, 3,  0,   0,       0, 0,  'h001C,  'h0021, 'h0021,  4,  0, 0, 0,   0};
    tbl[9]  = '{0, 0, 1, 0,  0,  0, 0, 0,  1,   'hFFFF,  0, 0,  'hFFFF,  'h0021, 'h001D,  4,  0, 0, 0,   0};
    tbl[10] = '{0, 0, 0, 0,  0,  1, 0, 0,  0,   0,       1, 0,  'h0000,  'h0021, 'h0000,  5,  1, 0, 0,   0};
    tbl[11] = '{0, 0, 0, 0,  1,  0, 0, 15, 0,   0,       0, 0,  'h004C,  'h0001, 'h0001,  4,  0, 0, 0,   0};
    tbl[12] = '{0, 0, 1, 0,  0,  0, 0, 0,  1,   'h0009,  0, 0,  'h0009,  'h0001, 'h004D,  4,  0, 0, 0,   0};

    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; resume = 1'b0;
    d_write_a = 1'b0; d_write_r = 1'b0; d_ld = 1'b0; d_st = 1'b0; d_br = 1'b0;
    d_jrl = 1'b0; d_interrupt = 1'b0; d_halt = 1'b0; d_immdt = 4'h0;
    cond_flag = 1'b0; r_value = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",    int'(state),    0);
    chk("rst_pc",       int'(pc),       0);
    chk("rst_epc",      int'(epc),      0);
    chk("rst_halted",   int'(halted),   0);
    chk("rst_dmem_req", int'(dmem_req), 0);
    chk("rst_imem_req", int'(imem_req), 0);
    chk("rst_strobes",  int'(a_we || r_we || ir_load), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_imem_req", int'(imem_req), 1);

    mon_en = 1'b1;
    for (int i = 0; i < 13; i++) run_instr(tbl[i]);
    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("sb_drained", exp_q.size(), 0);

    // HLT at pc 9.
    @(posedge clk); #1;
    d_write_a = 1'b0; d_write_r = 1'b0; d_br = 1'b0; d_interrupt = 1'b0; d_halt = 1'b1;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("hlt_decode", int'(state), 1);
    @(posedge clk); #1;
    chk("hlt_exec", int'(state), 2);
    @(posedge clk); #1;
    chk("hlt_state",  int'(state),  5);
    chk("hlt_halted", int'(halted), 1);
    chk("hlt_pc",     int'(pc),     'h000A);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      imem_ack = (i % 2 == 0);
      @(negedge clk);
      if (imem_req || dmem_req || ir_load || state != 3'd5) bad++;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    chk("hlt_quiet", bad, 0);
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    d_halt = 1'b0;
    chk("resume_state",  int'(state),    0);
    chk("resume_halted", int'(halted),   0);
    chk("resume_req",    int'(imem_req), 1);

    // ST aborted by reset during the MEM wait.
    d_st = 1'b1;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_mem_state", int'(state),   3);
    chk("abort_mem_we",    int'(dmem_we), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_dmem_req", int'(dmem_req), 0);
    chk("abort_imem_req", int'(imem_req), 0);
    chk("abort_state",    int'(state),    0);
    chk("abort_pc",       int'(pc),       0);
    chk("abort_epc",      int'(epc),      0);
    chk("abort_strobes",  int'(a_we || r_we), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    d_st = 1'b0;
    @(posedge clk); #1;
    chk("abort_refetch", int'(imem_req), 1);
    chk("abort_pc_hold", int'(pc),       0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
